// File: rtl/rtc_disp_scan.sv
// Six-digit multiplexed seven-segment driver for HH:MM:SS with a per-frame digit snapshot.
// Optional macro RTC_DISP_BLANK_LZ_EN blanks the hours-tens digit when it is zero.
module rtc_disp_scan #(
  parameter int unsigned DWELL = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  input  logic [3:0] h0,
  input  logic [3:0] h1,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       colon,
  output logic       frame_start
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1011111;
      4'd1:    r = 7'b0000011;
      4'd2:    r = 7'b1110110;
      4'd3:    r = 7'b1110011;
      4'd4:    r = 7'b0101011;
      4'd5:    r = 7'b1111001;
      4'd6:    r = 7'b1111101;
      4'd7:    r = 7'b1000011;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1101011;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  logic [CW-1:0] cnt;
  logic [3:0]    snap [6];
  logic          step;
  logic [5:0]    an_next;
  logic [3:0]    digit_next;
  logic [6:0]    seg_next;

  always_comb begin
    step       = (cnt == CNT_LAST);
    an_next    = {an[4:0], an[5]};
    digit_next = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (an_next[i]) digit_next = snap[i];
    end
    seg_next = enc(digit_next);
`ifdef RTC_DISP_BLANK_LZ_EN
    if (an_next[5] && (snap[5] == 4'd0)) seg_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      an          <= 6'b000001;
      seg         <= enc(4'd0);
      colon       <= 1'b1;
      frame_start <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) snap[i] <= '0;
    end else begin
      frame_start <= 1'b0;
      if (step) begin
        cnt <= '0;
        an  <= an_next;
        if (an[5]) begin
          // Wrap edge: bit0 shows the live s0 directly, which equals the value being captured.
          snap[0]     <= s0;
          snap[1]     <= s1;
          snap[2]     <= m0;
          snap[3]     <= m1;
          snap[4]     <= h0;
          snap[5]     <= h1;
          seg         <= enc(s0);
          colon       <= ~s0[0];
          frame_start <= 1'b1;
        end else begin
          seg <= seg_next;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rtc_disp_scan.sv
// Self-checking bench for rtc_disp_scan: frame-position model plus directed literal checks.
module tb_rtc_disp_scan;

  localparam int unsigned DWELL = 4;
  localparam int unsigned FRAME = 6 * DWELL;
`ifdef RTC_DISP_BLANK_LZ_EN
  localparam logic [6:0] LZ_SEG = 7'b0000000;
`else
  localparam logic [6:0] LZ_SEG = 7'b1011111;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic [6:0] seg;
  logic [5:0] an;
  logic       colon, frame_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_disp_scan #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h0(h0), .h1(h1),
    .seg(seg), .an(an), .colon(colon), .frame_start(frame_start)
  );

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1011111; seg_tab[1]  = 7'b0000011;
    seg_tab[2]  = 7'b1110110; seg_tab[3]  = 7'b1110011;
    seg_tab[4]  = 7'b0101011; seg_tab[5]  = 7'b1111001;
    seg_tab[6]  = 7'b1111101; seg_tab[7]  = 7'b1000011;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1101011;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the frame follows from edges elapsed since reset release.
  int unsigned mk;
  logic [3:0]  msnap [6];
  logic        check_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mk = 0;
      for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
    end else begin
      mk++;
      if (mk % FRAME == 0) begin
        msnap[0] = s0; msnap[1] = s1; msnap[2] = m0;
        msnap[3] = m1; msnap[4] = h0; msnap[5] = h1;
      end
    end
  end

  always @(negedge clk) begin
    int unsigned pos;
    logic [6:0]  exp_seg;
    logic        exp_col;
    logic        exp_fs;
    if (check_en) begin
      pos     = (mk / DWELL) % 6;
      exp_seg = seg_tab[msnap[pos]];
`ifdef RTC_DISP_BLANK_LZ_EN
      if (pos == 5 && msnap[5] == 4'd0) exp_seg = 7'b0000000;
`endif
      exp_col = ~msnap[0][0];
      exp_fs  = (mk != 0) && (mk % FRAME == 0);
      chk("model_an", 32'(an), 32'(1) << pos);
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_colon", 32'(colon), 32'(exp_col));
      chk("model_frame_start", 32'(frame_start), 32'(exp_fs));
    end
  end

  int unsigned kd;
  task automatic tick();
    @(negedge clk);
    kd++;
  endtask
  task automatic go(input int unsigned t);
    while (kd < t) tick();
  endtask

  initial begin
    h1 = 4'd1; h0 = 4'd2; m1 = 4'd3; m0 = 4'd4; s1 = 4'd5; s0 = 4'd6;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_an", 32'(an), 32'(6'b000001));
    chk("rst_seg", 32'(seg), 32'(7'b1011111));
    chk("rst_colon", 32'(colon), 32'(1'b1));
    chk("rst_fs", 32'(frame_start), 32'(1'b0));
    rst = 1'b0;
    kd = 0;

    go(3);  chk("hold_an", 32'(an), 32'(6'b000001));
            chk("hold_seg", 32'(seg), 32'(7'b1011111));
    go(4);  chk("first_step_an", 32'(an), 32'(6'b000010));
            chk("first_step_seg", 32'(seg), 32'(7'b1011111));
    go(20); chk("first_h1_an", 32'(an), 32'(6'b100000));
            chk("first_h1_seg", 32'(seg), 32'(LZ_SEG));
    go(24); chk("wrap_an", 32'(an), 32'(6'b000001));
            chk("wrap_seg", 32'(seg), 32'(7'b1111101));
            chk("wrap_fs", 32'(frame_start), 32'(1'b1));
            chk("wrap_colon", 32'(colon), 32'(1'b1));
    go(25); chk("fs_pulse_end", 32'(frame_start), 32'(1'b0));
            h1 = 4'd0;
    go(28); chk("s1_an", 32'(an), 32'(6'b000010));
            chk("s1_seg", 32'(seg), 32'(7'b1111001));
    go(32); chk("m0_an", 32'(an), 32'(6'b000100));
            chk("m0_seg", 32'(seg), 32'(7'b0101011));
            s0 = 4'd7; m1 = 4'hA;
    go(36); chk("m1_old_seg", 32'(seg), 32'(7'b1110011));
    go(40); chk("h0_seg", 32'(seg), 32'(7'b1110110));
    go(44); chk("h1_an", 32'(an), 32'(6'b100000));
            chk("h1_old_seg", 32'(seg), 32'(7'b0000011));
    go(48); chk("wrap2_seg", 32'(seg), 32'(7'b1000011));
            chk("wrap2_colon", 32'(colon), 32'(1'b0));
            chk("wrap2_fs", 32'(frame_start), 32'(1'b1));
    go(60); chk("bad_bcd_an", 32'(an), 32'(6'b001000));
            chk("bad_bcd_seg", 32'(seg), 32'(7'b1111111));
    go(68); chk("lz_an", 32'(an), 32'(6'b100000));
            chk("lz_seg", 32'(seg), 32'(LZ_SEG));
    go(90); chk("pre_rst_an", 32'(an), 32'(6'b010000));
    rst = 1'b1;
    tick();
    chk("midrst_an", 32'(an), 32'(6'b000001));
    chk("midrst_seg", 32'(seg), 32'(7'b1011111));
    chk("midrst_colon", 32'(colon), 32'(1'b1));
    chk("midrst_fs", 32'(frame_start), 32'(1'b0));
    rst = 1'b0;
    kd = 0;
    go(3);  chk("midrst_hold_an", 32'(an), 32'(6'b000001));
    go(4);  chk("midrst_step_an", 32'(an), 32'(6'b000010));
            chk("midrst_cleared_seg", 32'(seg), 32'(7'b1011111));
    go(20); chk("midrst_h1_seg", 32'(seg), 32'(LZ_SEG));
    go(24); chk("midrst_wrap_seg", 32'(seg), 32'(7'b1000011));
            chk("midrst_wrap_colon", 32'(colon), 32'(1'b0));
            chk("midrst_wrap_fs", 32'(frame_start), 32'(1'b1));
    go(26);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
